stepgen_bank: RTL

STEPGEN_BANK -- requirements
Module: stepgen_bank

---
 rtl/remora_pkg.sv | 16 +
 rtl/stepgen_channel.sv | 113 +++++++++++
 rtl/stepgen_bank.sv | 37 +++
 3 files changed

// File: rtl/remora_pkg.sv
// rtl/remora_pkg.sv - shared state type and timer sizing for the step generator bank
package remora_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIR_WAIT,
      ST_HIGH,
      ST_LOW
   } step_state_e;

   // Timers are sized for the largest legal pulse/setup length so every
   // channel shares one width regardless of its parameters.
   localparam int MAX_TIMER_CYC = 4095;
   localparam int TIMER_W       = $clog2(MAX_TIMER_CYC + 1);

endpackage

// File: rtl/stepgen_channel.sv
// rtl/stepgen_channel.sv - one step/dir channel: phase accumulator, pulse FSM, position count
module stepgen_channel
   import remora_pkg::*;
#(
   parameter int ACC_W         = 32,
   parameter int PULSE_CYC     = 96,
   parameter int DIR_SETUP_CYC = 96
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             enable_i,
   input  logic             halt_i,
   input  logic [ACC_W-1:0] freq_cmd_i,
   output logic [ACC_W-1:0] feedback_o,
   output logic             stp_o,
   output logic             dir_o,
   output logic             overrun_o
);

   localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYC - 1);
   localparam logic [TIMER_W-1:0] DIR_LOAD   = TIMER_W'(DIR_SETUP_CYC - 1);

   step_state_e        state;
   logic [TIMER_W-1:0] timer;
   logic [ACC_W-1:0]   acc;
   logic               pending;
   logic               pend_dir;

   logic               active;
   logic               carry;
   logic               enter_high;
   logic [ACC_W-1:0]   mag;
   logic [ACC_W-1:0]   sum;

   always_comb begin
      active = enable_i & ~halt_i;
      // Two's-complement negate; the most negative command maps to 2^(ACC_W-1).
      mag = freq_cmd_i[ACC_W-1] ? (~freq_cmd_i + ACC_W'(1)) : freq_cmd_i;
      {carry, sum} = {1'b0, acc} + {1'b0, mag};
      enter_high = 1'b0;
      case (state)
         ST_IDLE:     enter_high = active & pending & (pend_dir == dir_o);
         ST_DIR_WAIT: enter_high = (timer == '0);
         default:     enter_high = 1'b0;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         timer      <= '0;
         acc        <= '0;
         pending    <= 1'b0;
         pend_dir   <= 1'b0;
         stp_o      <= 1'b0;
         dir_o      <= 1'b0;
         feedback_o <= '0;
         overrun_o  <= 1'b0;
      end else begin
         acc <= active ? sum : '0;

         // A carry landing on the HIGH-entry edge re-arms pending rather than overrunning.
         if (!active) begin
            pending <= 1'b0;
         end else if (carry) begin
            if (pending && !enter_high) begin
               overrun_o <= 1'b1;
            end else begin
               pending  <= 1'b1;
               pend_dir <= ~freq_cmd_i[ACC_W-1];
            end
         end else if (enter_high) begin
            pending <= 1'b0;
         end

         if (enter_high) begin
            state      <= ST_HIGH;
            stp_o      <= 1'b1;
            timer      <= PULSE_LOAD;
            feedback_o <= dir_o ? feedback_o + ACC_W'(1) : feedback_o - ACC_W'(1);
         end else begin
            case (state)
               ST_IDLE: begin
                  if (active && pending) begin
                     dir_o <= pend_dir;
                     state <= ST_DIR_WAIT;
                     timer <= DIR_LOAD;
                  end
               end
               ST_DIR_WAIT: timer <= timer - TIMER_W'(1);
               ST_HIGH: begin
                  if (timer == '0) begin
                     state <= ST_LOW;
                     stp_o <= 1'b0;
                     timer <= PULSE_LOAD;
                  end else begin
                     timer <= timer - TIMER_W'(1);
                  end
               end
               ST_LOW: begin
                  if (timer == '0) begin
                     state <= ST_IDLE;
                  end else begin
                     timer <= timer - TIMER_W'(1);
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/stepgen_bank.sv
// rtl/stepgen_bank.sv - bank of independent step/dir generators with packed command/feedback buses
module stepgen_bank #(
   parameter int NUM_CH        = 5,
   parameter int ACC_W         = 32,
   parameter int PULSE_CYC     = 96,
   parameter int DIR_SETUP_CYC = 96
) (
   input  logic                    sysclk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       enable_i,
   input  logic                    halt_i,
   input  logic [NUM_CH*ACC_W-1:0] freq_cmd_i,
   output logic [NUM_CH*ACC_W-1:0] feedback_o,
   output logic [NUM_CH-1:0]       stp_o,
   output logic [NUM_CH-1:0]       dir_o,
   output logic [NUM_CH-1:0]       overrun_o
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      stepgen_channel #(
         .ACC_W         (ACC_W),
         .PULSE_CYC     (PULSE_CYC),
         .DIR_SETUP_CYC (DIR_SETUP_CYC)
      ) u_ch (
         .sysclk     (sysclk),
         .rst_n      (rst_n),
         .enable_i   (enable_i[g]),
         .halt_i     (halt_i),
         .freq_cmd_i (freq_cmd_i[g*ACC_W +: ACC_W]),
         .feedback_o (feedback_o[g*ACC_W +: ACC_W]),
         .stp_o      (stp_o[g]),
         .dir_o      (dir_o[g]),
         .overrun_o  (overrun_o[g])
      );
   end

endmodule
